// File: rtl/fall_rate_ticker.sv
`default_nettype none
//------------------------------------------------------------------------------
// fall_rate_ticker: per-column "advance one row" pulses for the falling letters.
// The step period shrinks with the score level; columns start staggered.
// Rev 1.0
//------------------------------------------------------------------------------
module fall_rate_ticker #(
  parameter int BASE_PERIOD     = 25000000,
  parameter int MIN_PERIOD      = 5000000,
  parameter int PERIOD_DEC      = 1000000,
  parameter int SCORE_PER_LEVEL = 4,
  parameter int STAGGER_TICKS   = 8,
  parameter int PW              = 25
) (
  input  logic          clock,
  input  logic          reset_signal,
  input  logic          run,
  input  logic          pause,
  input  logic [7:0]    score,
  output logic [2:0]    step,
  output logic [3:0]    level,
  output logic [PW-1:0] period
);

  localparam int            c_TICK_SAT = 2 * STAGGER_TICKS;
  localparam int            c_TCW      = $clog2(c_TICK_SAT + 1);
  localparam logic [PW+3:0] c_BASE     = (PW+4)'(BASE_PERIOD);
  localparam logic [PW+3:0] c_MIN      = (PW+4)'(MIN_PERIOD);
  localparam logic [PW+3:0] c_DEC      = (PW+4)'(PERIOD_DEC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_cnt;
  logic [PW-1:0]    r_period;
  logic [c_TCW-1:0] r_tick_count;
  logic [2:0]       r_step;
  logic [3:0]       r_level;

  logic [7:0]       w_score_lvl;
  logic [3:0]       w_level_target;
  logic [PW+3:0]    w_dec;
  logic [PW-1:0]    w_period_target;
  logic             w_tick_due;

  assign w_score_lvl    = score / 8'(SCORE_PER_LEVEL);
  assign w_level_target = (w_score_lvl > 8'd15) ? 4'd15 : w_score_lvl[3:0];

  // Wide arithmetic so a large level clamps to the floor instead of wrapping.
  assign w_dec           = (PW+4)'(r_level) * c_DEC;
  assign w_period_target = (w_dec >= (c_BASE - c_MIN)) ? PW'(MIN_PERIOD)
                                                       : PW'(c_BASE - w_dec);
  assign w_tick_due      = (r_cnt == (r_period - PW'(1)));

  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_tick_count <= '0;
      r_step       <= 3'b000;
      r_level      <= 4'd0;
      r_period     <= PW'(BASE_PERIOD);
    end else begin
      r_level <= w_level_target;
      r_step  <= 3'b000;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state      <= S_RUN;
            r_cnt        <= '0;
            r_tick_count <= '0;
            r_period     <= w_period_target;
          end
        end
        S_RUN, S_PAUSED: begin
          if (!run) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_tick_count <= '0;
          end else if (pause) begin
            r_state <= S_PAUSED;
          end else begin
            r_state <= S_RUN;
            if (w_tick_due) begin
              r_cnt    <= '0;
              r_period <= w_period_target;
              // Column i joins once i*STAGGER_TICKS ticks have already elapsed.
              for (int i = 0; i < 3; i++) begin
                r_step[i] <= (int'(r_tick_count) >= i * STAGGER_TICKS);
              end
              if (int'(r_tick_count) < c_TICK_SAT) begin
                r_tick_count <= r_tick_count + c_TCW'(1);
              end
            end else begin
              r_cnt <= r_cnt + PW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign step   = r_step;
  assign level  = r_level;
  assign period = r_period;

endmodule
`default_nettype wire
